keypad_scanner: RTL and testbench

- Upstream stage of the keylock datapath: scans the 3x3 keypad, synchronises and debounces the columns, and produces the digit code plus the press-level signal.
- `button`/`bstate` feed the controller, key list and edge detector in the top-level lock.
- Adds `key_strobe`, a clean single-cycle press pulse, so consumers need no edge detect of their own.

---
 rtl/keypad_pkg.sv | 23 ++
 rtl/sync2.sv | 30 +++
 rtl/keypad_scanner.sv | 162 ++++++++++++++++
 tb/tb_keypad_scanner.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and helpers for the 3x3 keypad scanner.
//   state_e   scanner FSM states
//   KEY_NONE  button value before any accepted press
//   NUM_ROWS / NUM_COLS  keypad geometry
//   key_code  (row, col) -> digit code 1..9, both indices 0-based
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN,
    DEB_PRESS,
    HELD,
    DEB_RELEASE
  } state_e;

  localparam logic [3:0]  KEY_NONE = 4'd0;
  localparam int unsigned NUM_ROWS = 3;
  localparam int unsigned NUM_COLS = 3;

  function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
    return 4'(NUM_COLS) * {2'b00, row} + {2'b00, col} + 4'd1;
  endfunction

endpackage

// File: rtl/sync2.sv
// sync2: two-flop synchroniser for the keypad column senses.
//   i_clk  clock
//   i_rst  asynchronous active-high reset; both stages reset to 1 (columns idle high)
//   i_d    asynchronous column inputs
//   o_q    synchronised column values
module sync2
  import keypad_pkg::*;
(
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [NUM_COLS-1:0] i_d,
  output logic [NUM_COLS-1:0] o_q
);

  logic [NUM_COLS-1:0] r_meta;
  logic [NUM_COLS-1:0] r_sync;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta <= '1;
      r_sync <= '1;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 3x3 keypad, debounces presses/releases and reports the key.
//   hwclk                     system clock
//   reset                     asynchronous active-high reset
//   keypad_r1..r3             active-low row drives (one row low at a time)
//   keypad_c1..c3             pulled-up column senses, low = key closed on driven row
//   button                    last accepted key code 1..9, 0 until first press
//   bstate                    high while the accepted key is held (debounced)
//   key_strobe                one-cycle pulse per accepted press
// Optional build macro KEYPAD_AUTOREPEAT_EN: while held, key_strobe repeats after
// REPEAT_DELAY cycles and then every REPEAT_PERIOD cycles.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV      = 12000,
  parameter int unsigned DEBOUNCE_CYC  = 240000
`ifdef KEYPAD_AUTOREPEAT_EN
  ,
  parameter int unsigned REPEAT_DELAY  = 6000000,
  parameter int unsigned REPEAT_PERIOD = 2400000
`endif
) (
  input  logic       hwclk,
  input  logic       reset,
  output logic       keypad_r1,
  output logic       keypad_r2,
  output logic       keypad_r3,
  input  logic       keypad_c1,
  input  logic       keypad_c2,
  input  logic       keypad_c3,
  output logic [3:0] button,
  output logic       bstate,
  output logic       key_strobe
);

  localparam int unsigned DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned BW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] DEB_LAST   = BW'(DEBOUNCE_CYC - 1);

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int unsigned HW = (REPEAT_DELAY > 1) ? $clog2(REPEAT_DELAY) : 1;
  localparam logic [HW-1:0] HOLD_LAST   = HW'(REPEAT_DELAY - 1);
  // Reloading here makes every later repeat land REPEAT_PERIOD cycles apart.
  localparam logic [HW-1:0] HOLD_RELOAD = HW'(REPEAT_DELAY - REPEAT_PERIOD);
  logic [HW-1:0] r_hold;
`endif

  logic [2:0]    w_cols;
  logic [2:0]    w_cs;
  logic [1:0]    w_low_col;
  logic [1:0]    w_row_next;
  logic          w_any_low;
  logic          w_cand_high;

  state_e        r_state;
  logic [1:0]    r_row;
  logic [1:0]    r_col;
  logic [DW-1:0] r_dwell;
  logic [BW-1:0] r_deb;
  logic [3:0]    r_button;
  logic          r_bstate;
  logic          r_strobe;

  assign w_cols = {keypad_c3, keypad_c2, keypad_c1};

  sync2 u_sync2 (
    .i_clk (hwclk),
    .i_rst (reset),
    .i_d   (w_cols),
    .o_q   (w_cs)
  );

  // Lowest-index closed column wins when several keys share the driven row.
  assign w_low_col   = !w_cs[0] ? 2'd0 : (!w_cs[1] ? 2'd1 : 2'd2);
  assign w_any_low   = ~&w_cs;
  assign w_cand_high = w_cs[r_col];
  assign w_row_next  = (r_row == 2'(NUM_ROWS - 1)) ? 2'd0 : r_row + 2'd1;

  always_ff @(posedge hwclk or posedge reset) begin
    if (reset) begin
      r_state  <= SCAN;
      r_row    <= 2'd0;
      r_col    <= 2'd0;
      r_dwell  <= '0;
      r_deb    <= '0;
      r_button <= KEY_NONE;
      r_bstate <= 1'b0;
      r_strobe <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
      r_hold   <= '0;
`endif
    end else begin
      r_strobe <= 1'b0;
      unique case (r_state)
        SCAN: begin
          // Sample only at the end of the dwell so the synchroniser has settled on this row.
          if (r_dwell == DWELL_LAST) begin
            r_dwell <= '0;
            if (w_any_low) begin
              r_col   <= w_low_col;
              r_deb   <= '0;
              r_state <= DEB_PRESS;
            end else begin
              r_row <= w_row_next;
            end
          end else begin
            r_dwell <= r_dwell + DW'(1);
          end
        end
        DEB_PRESS: begin
          if (w_cand_high) begin
            r_row   <= w_row_next;
            r_state <= SCAN;
          end else if (r_deb == DEB_LAST) begin
            r_button <= key_code(r_row, r_col);
            r_bstate <= 1'b1;
            r_strobe <= 1'b1;
            r_state  <= HELD;
          end else begin
            r_deb <= r_deb + BW'(1);
          end
        end
        HELD: begin
          if (w_cand_high) begin
            r_deb   <= '0;
            r_state <= DEB_RELEASE;
`ifdef KEYPAD_AUTOREPEAT_EN
            r_hold  <= '0;
`endif
          end
`ifdef KEYPAD_AUTOREPEAT_EN
          else if (r_hold == HOLD_LAST) begin
            r_hold   <= HOLD_RELOAD;
            r_strobe <= 1'b1;
          end else begin
            r_hold <= r_hold + HW'(1);
          end
`endif
        end
        DEB_RELEASE: begin
          if (!w_cand_high) begin
            r_state <= HELD;
          end else if (r_deb == DEB_LAST) begin
            r_bstate <= 1'b0;
            r_row    <= w_row_next;
            r_state  <= SCAN;
          end else begin
            r_deb <= r_deb + BW'(1);
          end
        end
      endcase
    end
  end

  assign keypad_r1  = (r_row != 2'd0);
  assign keypad_r2  = (r_row != 2'd1);
  assign keypad_r3  = (r_row != 2'd2);
  assign button     = r_button;
  assign bstate     = r_bstate;
  assign key_strobe = r_strobe;

endmodule

// File: tb/tb_keypad_scanner.sv
module tb_keypad_scanner;

  localparam int SD  = 4;
  localparam int DB  = 16;
  localparam int LAT = 3 * SD + DB + 2;
`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int RD    = 64;
  localparam int RP    = 32;
  localparam int HOLD1 = 30;
`else
  localparam int HOLD1 = 200;
`endif

  logic       hwclk = 1'b0;
  logic       reset = 1'b1;
  logic       keypad_r1, keypad_r2, keypad_r3;
  logic       keypad_c1, keypad_c2, keypad_c3;
  logic [3:0] button;
  logic       bstate, key_strobe;

  // Physical key matrix: bit 3*row+col set = key closed.
  logic [8:0] keys = '0;

  int         passed = 0;
  int         total = 0;
  int         strobe_cnt = 0;
  int         rise_cnt = 0;
  logic       bstate_prev = 1'b0;
  logic [3:0] exp_button = 4'd0;

  typedef struct {
    logic [8:0] km;
    logic [3:0] code;
  } vec_t;
  vec_t tbl [11];

  keypad_scanner #(
    .SCAN_DIV     (SD),
    .DEBOUNCE_CYC (DB)
`ifdef KEYPAD_AUTOREPEAT_EN
    ,
    .REPEAT_DELAY (RD),
    .REPEAT_PERIOD(RP)
`endif
  ) dut (
    .hwclk     (hwclk),
    .reset     (reset),
    .keypad_r1 (keypad_r1),
    .keypad_r2 (keypad_r2),
    .keypad_r3 (keypad_r3),
    .keypad_c1 (keypad_c1),
    .keypad_c2 (keypad_c2),
    .keypad_c3 (keypad_c3),
    .button    (button),
    .bstate    (bstate),
    .key_strobe(key_strobe)
  );

  always #5 hwclk = ~hwclk;

  assign keypad_c1 = ~((~keypad_r1 & keys[0]) | (~keypad_r2 & keys[3]) | (~keypad_r3 & keys[6]));
  assign keypad_c2 = ~((~keypad_r1 & keys[1]) | (~keypad_r2 & keys[4]) | (~keypad_r3 & keys[7]));
  assign keypad_c3 = ~((~keypad_r1 & keys[2]) | (~keypad_r2 & keys[5]) | (~keypad_r3 & keys[8]));

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge hwclk);
    #1;
  endtask

  // Strobe/rise bookkeeping, sampled mid-cycle.
  always @(negedge hwclk) begin
    if (key_strobe) begin
      strobe_cnt++;
      check("strobe_only_while_bstate", bstate, 1);
    end
    if (bstate && !bstate_prev) rise_cnt++;
    bstate_prev = bstate;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  // Reference rule: lowest closed column on the row wins, code = 3*row + col + 1.
  function automatic logic [3:0] model_code(input int row, input int mask);
    for (int c = 0; c < 3; c++) if (((mask >> c) & 1) != 0) return 4'(3 * row + c + 1);
    return 4'd0;
  endfunction

  function automatic logic row_low(input int idx);
    case (idx)
      0: return !keypad_r1;
      1: return !keypad_r2;
      default: return !keypad_r3;
    endcase
  endfunction

  task automatic wait_level(input logic lvl, input int bound, output bit ok, output int n);
    ok = 0;
    n  = 0;
    for (int i = 0; i < bound; i++) begin
      tick();
      n++;
      if (bstate == lvl) begin
        ok = 1;
        break;
      end
    end
  endtask

  // Returns just after the given row becomes driven.
  task automatic wait_row(input int idx, output bit ok);
    bit seen_off;
    seen_off = 0;
    ok = 0;
    for (int i = 0; i < 8 * SD; i++) begin
      tick();
      if (!row_low(idx)) seen_off = 1;
      else if (seen_off) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic press_and_check(input string name, input logic [8:0] km,
                                 input logic [3:0] code, input int hold);
    bit ok;
    int n, s0, r0;
    s0 = strobe_cnt;
    r0 = rise_cnt;
    keys = km;
    wait_level(1'b1, LAT, ok, n);
    check({name, " accept_within_latency"}, ok, 1);
    check({name, " strobe_on_accept"}, key_strobe, 1);
    check({name, " button"}, button, code);
    exp_button = code;
    tick(hold);
    keys = '0;
    tick(DB);
    check({name, " bstate_during_release_debounce"}, bstate, 1);
    wait_level(1'b0, 6, ok, n);
    check({name, " release_within_bound"}, ok, 1);
    check({name, " button_kept"}, button, code);
    tick();
    check({name, " one_strobe"}, strobe_cnt - s0, 1);
    check({name, " one_rise"}, rise_cnt - r0, 1);
  endtask

  task automatic check_reset_values(input string name);
    check({name, " button"}, button, 0);
    check({name, " bstate"}, bstate, 0);
    check({name, " strobe"}, key_strobe, 0);
    check({name, " r1"}, keypad_r1, 0);
    check({name, " r2"}, keypad_r2, 1);
    check({name, " r3"}, keypad_r3, 1);
  endtask

  initial begin
    bit ok, stayed;
    int n, s0, r0;
    int offs[$];
    int exp_offs[4];

    tbl = '{
      '{9'h001, 4'd1}, '{9'h002, 4'd2}, '{9'h004, 4'd3},
      '{9'h008, 4'd4}, '{9'h010, 4'd5}, '{9'h020, 4'd6},
      '{9'h040, 4'd7}, '{9'h080, 4'd8}, '{9'h100, 4'd9},
      '{9'h006, 4'd2}, '{9'h1c0, 4'd7}
    };

    // Power-on reset state.
    tick(3);
    check_reset_values("reset_initial");
    reset = 1'b0;
    tick(2);

    // Key 5 held for a long time: one press, one strobe.
    press_and_check("key5_long", 9'h010, 4'd5, HOLD1);

    // Every key plus two same-row multi-key cases.
    for (int i = 0; i < 11; i++) begin
      press_and_check($sformatf("table%0d", i), tbl[i].km, tbl[i].code, 10);
      tick(3);
    end

    // Press bounce on key 1: accept only after a long enough stable low.
    wait_row(0, ok);
    check("bounce sync_row", ok, 1);
    s0 = strobe_cnt;
    keys = 9'h001; tick(5);
    keys = 9'h000; tick(3);
    keys = 9'h001;
    check("bounce no_strobe_during_bounce", strobe_cnt - s0, 0);
    wait_level(1'b1, LAT, ok, n);
    check("bounce accept", ok, 1);
    check("bounce stable_low_needed", (n >= DB) ? 1 : 0, 1);
    check("bounce strobe_on_accept", key_strobe, 1);
    check("bounce button", button, 1);
    exp_button = 4'd1;
    tick(5);
    keys = '0;
    wait_level(1'b0, DB + 6, ok, n);
    check("bounce release", ok, 1);
    tick();
    check("bounce one_strobe", strobe_cnt - s0, 1);

    // Short glitch on key 9: ignored, scanning resumes at row 1.
    wait_row(2, ok);
    check("glitch sync_row", ok, 1);
    s0 = strobe_cnt;
    r0 = rise_cnt;
    keys = 9'h100;
    tick(10);
    keys = '0;
    ok = 0;
    for (int i = 0; i < 3 * SD + 6; i++) begin
      tick();
      if (!keypad_r1) begin
        ok = 1;
        break;
      end
    end
    check("glitch scan_resumes_r1", ok, 1);
    tick(30);
    check("glitch no_strobe", strobe_cnt - s0, 0);
    check("glitch no_rise", rise_cnt - r0, 0);
    check("glitch bstate", bstate, 0);
    check("glitch button_unchanged", button, exp_button);

    // Key 9 with a bouncy release: bstate holds through the bounce and falls once.
    s0 = strobe_cnt;
    keys = 9'h100;
    wait_level(1'b1, LAT, ok, n);
    check("relbounce accept", ok, 1);
    check("relbounce button", button, 9);
    exp_button = 4'd9;
    tick(5);
    r0 = rise_cnt;
    stayed = 1;
    keys = 9'h000;
    for (int i = 0; i < 8; i++) begin tick(); stayed &= bstate; end
    keys = 9'h100;
    for (int i = 0; i < 2; i++) begin tick(); stayed &= bstate; end
    keys = 9'h000;
    for (int i = 0; i < DB; i++) begin tick(); stayed &= bstate; end
    check("relbounce bstate_held", stayed, 1);
    wait_level(1'b0, 6, ok, n);
    check("relbounce falls", ok, 1);
    tick();
    check("relbounce one_strobe", strobe_cnt - s0, 1);
    check("relbounce no_second_rise", rise_cnt - r0, 0);
    check("relbounce button_kept", button, 9);

    // Reset during press debounce.
    wait_row(0, ok);
    s0 = strobe_cnt;
    keys = 9'h001;
    tick(8);
    #1 reset = 1'b1;
    #1 check_reset_values("reset_deb_press");
    keys = '0;
    tick(2);
    reset = 1'b0;
    tick(3);
    check("reset_deb_press no_strobe", strobe_cnt - s0, 0);
    check("reset_deb_press bstate_after", bstate, 0);

    // Reset while a key is held.
    s0 = strobe_cnt;
    keys = 9'h002;
    wait_level(1'b1, LAT, ok, n);
    check("reset_held accept", ok, 1);
    check("reset_held button", button, 2);
    tick(3);
    #1 reset = 1'b1;
    #1 check_reset_values("reset_held");
    keys = '0;
    tick(2);
    reset = 1'b0;
    tick(3);
    check("reset_held strobes", strobe_cnt - s0, 1);
    exp_button = 4'd0;

    // Randomised single-row presses against the code model.
    for (int it = 0; it < 20; it++) begin
      int r, m, hold;
      r    = int'($urandom_range(0, 2));
      m    = int'($urandom_range(1, 7));
      hold = int'($urandom_range(5, 30));
      press_and_check($sformatf("rand%0d", it), 9'(m << (3 * r)), model_code(r, m), hold);
      tick(int'($urandom_range(1, 10)));
    end

`ifdef KEYPAD_AUTOREPEAT_EN
    // Auto-repeat on key 7.
    exp_offs = '{RD, RD + RP, RD + 2 * RP, RD + 3 * RP};
    keys = 9'h040;
    wait_level(1'b1, LAT, ok, n);
    check("repeat accept", ok, 1);
    check("repeat strobe_on_accept", key_strobe, 1);
    stayed = 1;
    for (int k = 1; k <= 170; k++) begin
      tick();
      if (key_strobe) offs.push_back(k);
      stayed &= (bstate == 1'b1) && (button == 4'd7);
    end
    keys = '0;
    check("repeat count", offs.size(), 4);
    for (int j = 0; j < 4; j++)
      check($sformatf("repeat offset%0d", j), (j < offs.size()) ? offs[j] : -1, exp_offs[j]);
    check("repeat outputs_steady", stayed, 1);
    wait_level(1'b0, DB + 6, ok, n);
    check("repeat release", ok, 1);
`else
    exp_offs = '{0, 0, 0, 0};
    offs.delete();
    check("no_repeat queue_empty", offs.size() + exp_offs[0], 0);
`endif

    tick(2);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
